// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  // Control state. IDLE accepts operands, RUN steps digits, DONE holds the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps needed to cover the full operand width.
  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width able to hold values 0..steps.
  function automatic int calc_cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor: {bo, d} = x - y - bi.
// Built as a chain of single-bit full-subtractor cells.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  // br[i] is the borrow into bit i; br[DIGIT] leaves the digit.
  logic [DIGIT:0] br;

  assign br[0] = bi;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi = gi + 1) begin : gen_bit
      // Per-bit difference and borrow: borrow when x < y + borrow-in.
      assign d[gi]      = x[gi] ^ y[gi] ^ br[gi];
      assign br[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & br[gi]);
    end
  endgenerate

  assign bo = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock.
// Operands are latched on acceptance, shifted through a single digit cell least
// significant digit first, and the result is held until the consumer takes it.
// Optional build macro SERIAL_SUB_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = calc_steps(WIDTH, DIGIT);
  localparam int CW = calc_cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic             step;
  logic [DIGIT-1:0] digit_d;
  logic             digit_bo;
  logic [WIDTH-1:0] diff_shift;

  // Single digit cell shared across all steps; the borrow reg chains digits.
  sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x (a_reg[DIGIT-1:0]),
    .y (b_reg[DIGIT-1:0]),
    .bi(borrow_reg),
    .d (digit_d),
    .bo(digit_bo)
  );

  // New digit enters at the top so after N steps the LSD sits at bit 0.
  generate
    if (DIGIT == WIDTH) begin : gen_single_step
      assign diff_shift = digit_d;
    end else begin : gen_multi_step
      assign diff_shift = {digit_d, diff_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; in_ready depends on state only.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then shift one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= bin;
      cnt_reg    <= '0;
    end else if (step) begin
      a_reg      <= a_reg >> DIGIT;
      b_reg      <= b_reg >> DIGIT;
      diff_reg   <= diff_shift;
      borrow_reg <= digit_bo;
      cnt_reg    <= cnt_reg + CW'(1);
    end
  end

  assign diff = diff_reg;
  assign bout = borrow_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_reg;
  logic b_msb_reg;

  // Operand sign bits are shifted out during RUN, so keep copies from acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end
  end

  // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
  assign ovf = a_msb_reg ^ b_msb_reg ^ diff_reg[WIDTH-1] ^ borrow_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes reference results,
// a monitor pops and compares on every output handshake.
// Build with SERIAL_SUB_OVF_EN to also check the overflow output.
module tb_serial_subtractor;

  localparam int WIDTH = 16;
  parameter int DIGIT = 4;
  localparam int N = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  exp_t exp_q[$];
  int   lat_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  logic prev_valid = 1'b0;

  serial_subtractor #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .busy     (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: always ready, randomly stalling, or fully stalled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference: plain unsigned arithmetic for diff/borrow, signed range for overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mbin);
    exp_t   e;
    longint ua, ub, ur, sr, smax, smin;
    ua = longint'(ma);
    ub = longint'(mb);
    ur = ua - ub - longint'(mbin);
    e.bout = (ur < 0);
    if (ur < 0) ur = ur + (longint'(1) << WIDTH);
    e.diff = ur[WIDTH-1:0];
    sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    e.ovf = (sr > smax) || (sr < smin);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one operand set and wait (bounded) for acceptance.
  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                      input logic sbin, input bit push);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = sa;
    b = sb;
    bin = sbin;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && rst_n === 1'b1) begin
        if (push) begin
          exp_q.push_back(model(sa, sb, sbin));
          lat_q.push_back(cyc + 1);
        end
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: latency on each out_valid rise, result on each handshake.
  always @(negedge clk) begin
    exp_t e;
    int   acc;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (lat_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          acc = lat_q.pop_front();
          check("latency", cyc - acc, N);
        end
      end
      prev_valid = out_valid;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("txn diff=%h bout=%0d expect diff=%h bout=%0d", diff, bout, e.diff, e.bout);
          check("diff", diff, e.diff);
          check("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    int   seen;
    int   steps;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: basic, wrap, equal-with-borrow, overflow corners.
    rdy_mode = 0;
    send(16'h1234, 16'h0235, 1'b0, 1);
    send(16'h0000, 16'h0001, 1'b0, 1);
    send(16'h0005, 16'h0005, 1'b1, 1);
    send(16'h8000, 16'h0001, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1);
    drain();

    // Back-pressure with new operands waiting.
    rdy_mode = 2;
    @(posedge clk);
    send(16'hA5C3, 16'h3C5A, 1'b1, 1);
    e1 = model(16'hA5C3, 16'h3C5A, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    check("bp_reach_done", out_valid, 1);
    fork
      send(16'h0F0F, 16'h1111, 1'b0, 1);
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1);
          check("bp_diff", diff, e1.diff);
          check("bp_bout", bout, e1.bout);
          check("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid === 1'b1 && out_ready === 1'b1) break;
        end
        @(negedge clk);
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(negedge clk);
        check("bp_accept_ready", in_ready, 0);
        check("bp_accept_busy", busy, 1);
      end
    join
    drain();

    // Reset in the middle of an operation.
    steps = (N - 1 < 2) ? N - 1 : 2;
    send(16'hFFFF, 16'h0001, 1'b0, 0);
    repeat (steps) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_in_ready_after", in_ready, 1);

    // Random operands with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
